// File: rtl/sha2_256_core.sv
// rtl/sha2_256_core.sv - SHA-256/SHA-224 block compression engine, 1/2/4 rounds per clock.
// Optional abort input enabled by defining SHA2_ABORT_EN.
module sha2_256_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef SHA2_ABORT_EN
  input  logic         abort,
`endif
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  input  logic         mode,
  output logic         busy,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] R_STEP   = 6'(R);
  localparam logic [5:0] LAST_CNT = 6'(64 - R);

  if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ROUND, S_UPDATE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [5:0]    cnt_q;
  logic          last_q;
  logic          mode_q;
  logic [255:0]  digest_q;
  logic [31:0]   h_q   [8];
  logic [31:0]   v_q   [8];
  logic [31:0]   w_q   [16];
  logic [31:0]   v_rnd [8];
  logic [31:0]   w_rnd [16];
  logic [31:0]   h_sum [8];
  logic [255:0]  dig_sum;
  logic [31:0]   t1, t2, w_new;
  logic          go_idle;

`ifdef SHA2_ABORT_EN
  assign go_idle = abort;
`else
  assign go_idle = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    blk_ready = 1'b0;
    busy      = 1'b1;
    dig_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
        if (blk_valid) state_d = S_ROUND;
      end
      S_WAIT: begin
        blk_ready = 1'b1;
        if (blk_valid) state_d = S_ROUND;
      end
      S_ROUND:  if (cnt_q == LAST_CNT) state_d = S_UPDATE;
      S_UPDATE: state_d = last_q ? S_DONE : S_WAIT;
      S_DONE: begin
        dig_valid = 1'b1;
        if (dig_ready) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    if (go_idle) state_d = S_IDLE;
  end

  // R chained rounds; the 16-word window slides one word per round.
  always_comb begin
    v_rnd = v_q;
    w_rnd = w_q;
    t1    = '0;
    t2    = '0;
    w_new = '0;
    for (int r = 0; r < R; r++) begin
      t1 = v_rnd[7]
         + (rotr(v_rnd[4], 6) ^ rotr(v_rnd[4], 11) ^ rotr(v_rnd[4], 25))
         + ((v_rnd[4] & v_rnd[5]) ^ (~v_rnd[4] & v_rnd[6]))
         + K[cnt_q + 6'(r)] + w_rnd[0];
      t2 = (rotr(v_rnd[0], 2) ^ rotr(v_rnd[0], 13) ^ rotr(v_rnd[0], 22))
         + ((v_rnd[0] & v_rnd[1]) ^ (v_rnd[0] & v_rnd[2]) ^ (v_rnd[1] & v_rnd[2]));
      w_new = (rotr(w_rnd[14], 17) ^ rotr(w_rnd[14], 19) ^ (w_rnd[14] >> 10))
            + w_rnd[9]
            + (rotr(w_rnd[1], 7) ^ rotr(w_rnd[1], 18) ^ (w_rnd[1] >> 3))
            + w_rnd[0];
      for (int j = 7; j > 0; j--) v_rnd[j] = v_rnd[j-1];
      v_rnd[4] = v_rnd[4] + t1;
      v_rnd[0] = t1 + t2;
      for (int j = 0; j < 15; j++) w_rnd[j] = w_rnd[j+1];
      w_rnd[15] = w_new;
    end
  end

  always_comb begin
    dig_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_q[i] + v_q[i];
      dig_sum[255-32*i -: 32] = h_sum[i];
    end
    if (mode_q) dig_sum[31:0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      last_q   <= 1'b0;
      mode_q   <= 1'b0;
      digest_q <= '0;
    end else if (go_idle) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (blk_valid) begin
          mode_q <= mode;
          last_q <= blk_last;
          cnt_q  <= '0;
          for (int i = 0; i < 8; i++) begin
            h_q[i] <= mode ? IV224[i] : IV256[i];
            v_q[i] <= mode ? IV224[i] : IV256[i];
          end
          for (int j = 0; j < 16; j++) w_q[j] <= blk_data[511-32*j -: 32];
        end
        S_WAIT: if (blk_valid) begin
          last_q <= blk_last;
          v_q    <= h_q;
          for (int j = 0; j < 16; j++) w_q[j] <= blk_data[511-32*j -: 32];
        end
        S_ROUND: begin
          v_q   <= v_rnd;
          w_q   <= w_rnd;
          cnt_q <= cnt_q + R_STEP;
        end
        S_UPDATE: begin
          h_q   <= h_sum;
          cnt_q <= '0;
          if (last_q) digest_q <= dig_sum;
        end
        default: ;
      endcase
    end
  end

  assign digest = digest_q;

endmodule

// File: tb/tb_sha2_256_core.sv
// tb/tb_sha2_256_core.sv - scoreboard bench for sha2_256_core (define SHA2_ABORT_EN to cover abort).
module tb_sha2_256_core;
  parameter int RPC = 1;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         abort_tb = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic         mode = 1'b0;
  logic         busy;
  logic         dig_valid;
  logic         dig_ready = 1'b1;
  logic [255:0] digest;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [255:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha2_256_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef SHA2_ABORT_EN
    .abort     (abort_tb),
`endif
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .mode      (mode),
    .busy      (busy),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digest    (digest)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && dig_valid && dig_ready && !abort_tb) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_digest: got %h want none", digest);
      end else begin
        check("digest", digest, exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [511:0] d, input logic last, input logic m,
                      input logic push, input logic [255:0] want);
    bit ok = 0;
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = last;
    mode      = m;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (blk_ready) begin
        @(posedge clk);
        acc_cyc = cyc;
        ok = 1;
      end
    end
    #1;
    if (!ok) check("accept_timeout", 256'(0), 256'(1));
    if (ok && last && push) exp_q.push_back(want);
    blk_valid = 1'b0;
    blk_data  = '0;
  endtask

  task automatic latency(input string name);
    int n = 0;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (dig_valid) break;
    end
    check(name, 256'(n), 256'(64 / RPC + 1));
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      if (!busy && exp_q.size() == 0) ok = 1;
      else @(negedge clk);
    end
    if (!ok) check("idle_timeout", 256'(0), 256'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input logic [255:0] want_digest);
    check({name, "_busy"}, 256'(busy), 256'(0));
    check({name, "_dig_valid"}, 256'(dig_valid), 256'(0));
    check({name, "_blk_ready"}, 256'(blk_ready), 256'(1));
    check({name, "_digest"}, digest, want_digest);
  endtask

  initial begin
    int acc1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_idle("reset", 256'h0);

    send(BLK_ABC, 1'b1, 1'b0, 1'b1, D_ABC256);
    latency("lat_abc256");
    wait_idle();

    send(BLK_ABC, 1'b1, 1'b1, 1'b1, D_ABC224);
    latency("lat_abc224");
    wait_idle();

    send(BLK_M1, 1'b0, 1'b0, 1'b0, '0);
    acc1 = acc_cyc;
    send(BLK_M2, 1'b1, 1'b1, 1'b1, D_TWO);
    check("block_period", 256'(acc_cyc - acc1), 256'(64 / RPC + 2));
    latency("lat_two_block");
    wait_idle();

    dig_ready = 1'b0;
    send(BLK_EMPTY, 1'b1, 1'b0, 1'b1, D_EMPTY);
    latency("lat_empty");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 256'(dig_valid), 256'(1));
      check("hold_digest", digest, D_EMPTY);
    end
    @(posedge clk);
    #1 dig_ready = 1'b1;
    @(posedge clk);
    #1;
    check_idle("after_done", D_EMPTY);
    send(BLK_ABC, 1'b1, 1'b0, 1'b1, D_ABC256);
    latency("lat_abc_again");
    wait_idle();

    send(BLK_ABC, 1'b1, 1'b0, 1'b0, '0);
    repeat (30 / RPC) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    check_idle("mid_reset", 256'h0);
    send(BLK_ABC, 1'b1, 1'b0, 1'b1, D_ABC256);
    latency("lat_after_reset");
    wait_idle();

`ifdef SHA2_ABORT_EN
    send(BLK_M1, 1'b0, 1'b0, 1'b0, '0);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (blk_ready && busy) break;
    end
    check("reached_wait", 256'(blk_ready && busy), 256'(1));
    abort_tb = 1'b1;
    @(posedge clk);
    #1 abort_tb = 1'b0;
    check_idle("abort_wait", D_ABC256);

    dig_ready = 1'b0;
    send(BLK_EMPTY, 1'b1, 1'b0, 1'b0, '0);
    latency("lat_abort_done");
    abort_tb  = 1'b1;
    dig_ready = 1'b1;
    @(posedge clk);
    #1 abort_tb = 1'b0;
    check_idle("abort_done", D_EMPTY);
    send(BLK_ABC, 1'b1, 1'b1, 1'b1, D_ABC224);
    latency("lat_after_abort");
    wait_idle();
`endif

    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/sha2_256_core.md
Name: sha2_256_core

Overview:
- Parametrised next-generation SHA-2/256-family hashing engine.
- Accepts pre-padded 512-bit blocks over a valid/ready stream and runs 1, 2 or 4 compression rounds per clock.
- Supports SHA-256 and SHA-224 modes, selected per message.
- Returns the digest over a valid/ready output; sits between the padding/stream front-end and the result FIFO.

Parameters:
- ROUNDS_PER_CYCLE, 1, compression rounds per clock. Legal values are 1, 2, 4; any other value is an elaboration error.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- blk_valid  input  1  blk_data/blk_last/mode valid.
- blk_ready  output  1  core can accept a block.
- blk_data  input  512  padded block, word W0 in [511:480].
- blk_last  input  1  block is final block of message.
- mode  input  1  0 = SHA-256, 1 = SHA-224; sampled only on first block of message.
- busy  output  1  message in progress (not IDLE).
- dig_valid  output  1  digest available.
- dig_ready  input  1  downstream accepts digest.
- digest  output  256  H0 in [255:224]. In SHA-224 mode, [255:32] = H0..H6 and [31:0] = 0.

Behaviour:
- Reset is synchronous, active-low. Any rising edge with reset_n=0 forces:
  - state IDLE, dig_valid=0, digest=0, busy=0, round counter=0;
  - blk_ready=1 from the following cycle;
  - all in-progress hashing is discarded, including reset mid-ROUND or in DONE.
- States and decoded outputs:
  - IDLE: blk_ready=1, busy=0.
  - WAIT: blk_ready=1, busy=1.
  - ROUND: blk_ready=0, busy=1.
  - UPDATE: blk_ready=0, busy=1.
  - DONE: dig_valid=1, blk_ready=0, busy=1.
- IDLE:
  - Handshake (blk_valid & blk_ready): load H from the IV selected by mode (SHA-256 or SHA-224 IV).
  - Latch mode and blk_last; load W window[15:0] from blk_data; load a..h from the IV; go to ROUND.
- WAIT:
  - Handshake: load block, latch blk_last, load a..h from current H; go to ROUND.
  - mode is ignored in WAIT.
- ROUND:
  - Each cycle performs ROUNDS_PER_CYCLE chained rounds t..t+R-1.
  - Round counter advances by R.
  - W comes from a 16-word sliding window computed in place (σ0/σ1 schedule), with no 64-word memory.
  - K comes from an internal 64-entry constant table indexed by the round number.
  - Stays in ROUND for exactly 64/R cycles, then goes to UPDATE.
- UPDATE (one cycle):
  - H[i] <= H[i] + working var, modulo 2^32 per word.
  - Round counter cleared.
  - Go to DONE if the latched last flag is set, else WAIT.
  - The digest register loads on the DONE transition.
- DONE:
  - dig_valid=1; digest held stable until dig_valid & dig_ready.
  - On that handshake go to IDLE; blk_ready=1 the next cycle.
  - digest retains its value until overwritten by the next message's final UPDATE.
- Latency:
  - From the edge that accepts a block to the edge entering UPDATE: 64/R edges.
  - Last-block accept to dig_valid high: 64/R+1 edges (65, 33, 17 for R=1, 2, 4).
  - Multi-block message with zero gaps: 64/R+2 cycles per block.
- blk_valid while blk_ready=0 is ignored; blk_data need not be held after the handshake.
- dig_ready while dig_valid=0 has no effect.
- Back-to-back message: blk_valid may be asserted in the cycle after the DONE handshake and is accepted in IDLE.
- All additions are 32-bit wrap-around with no saturation.

Optional Feature:
- Macro SHA2_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit), placed after reset_n.
  - abort=1 at a rising edge forces state IDLE, dig_valid=0, round counter=0, busy=0, in any state.
  - digest is unchanged.
  - Abort has priority over a simultaneous blk or dig handshake; that handshake is not taken.
- Not defined: the port is absent and no abort logic is present.

Test Plan:
- R=1, mode=0, one block "abc" (blk_data=61626380_0…0_00000018, blk_last=1):
  - dig_valid rises exactly 65 edges after accept;
  - digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- R=4, mode=1, same block:
  - dig_valid after 17 edges;
  - digest[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, digest[31:0]=0.
- R=2, mode=0, two-block padded "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - first block has blk_last=0; second block is offered with blk_valid held high, accepted the cycle blk_ready returns;
  - digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  - mode toggled to 1 on block 2 has no effect.
- Backpressure: empty message (blk_data=80000000_0…0):
  - hold dig_ready=0 for 10 cycles; digest stays e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855 with dig_valid=1;
  - then dig_ready=1 → IDLE, blk_ready=1 next cycle; second "abc" message gives the correct digest.
- reset_n=0 for one edge at round 30 of a block:
  - busy=0, dig_valid=0, digest=0, blk_ready=1 next cycle;
  - a following "abc" message hashes correctly.
- SHA2_ABORT_EN: abort mid-WAIT of the two-block message:
  - IDLE, digest unchanged;
  - abort coincident with the DONE handshake leaves dig_valid=0 and the next message starts from the IV.
